// File: rtl/lut_cfg_pkg.sv
// -----------------------------------------------------------------------------
// lut_cfg_pkg
// Shared definitions for the LUT configuration loader: the controller state
// encoding, the default stream word width and the helpers that derive the
// number of stream words per frame and the word-counter width.
// -----------------------------------------------------------------------------
package lut_cfg_pkg;

    localparam int CONFIG_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Stream words needed to fill one frame (MEM_SIZE is a multiple of the word width).
    function automatic int words_of(input int mem_size, input int config_width);
        return mem_size / config_width;
    endfunction

    // Counter wide enough to hold 0..words, i.e. ceil(log2(words+1)), at least 1 bit.
    function automatic int cnt_width(input int words);
        return (words < 1) ? 1 : $clog2(words + 1);
    endfunction

endpackage

// File: rtl/lut_cfg_loader_if.sv
// -----------------------------------------------------------------------------
// lut_cfg_loader_if
// Valid/ready configuration stream carrying LUT truth-table words.
//   cfg_data  : stream word
//   cfg_valid : word present
//   cfg_last  : final word of the frame
//   cfg_ready : loader can accept a word
// master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface lut_cfg_loader_if
    import lut_cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH = CONFIG_WIDTH_DEFAULT
);

    logic [CONFIG_WIDTH-1:0] cfg_data;
    logic                    cfg_valid;
    logic                    cfg_last;
    logic                    cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        input  cfg_last,
        output cfg_ready
    );

endinterface

// File: rtl/lut_cfg_readback.sv
// -----------------------------------------------------------------------------
// lut_cfg_readback
// Readback checker: after a start pulse, walks the LUT address 0..MEM_SIZE-1
// one per cycle and compares the LUT output against the committed frame,
// remembering the first mismatching address.
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : one-cycle pulse; the walk begins on the following cycle
//   frame_i      : committed frame (stable for the whole walk)
//   lut_rdata_i  : LUT output bit, combinational from lut_addr_o
//   lut_addr_o   : address being checked (0 when idle)
//   last_o       : high during the cycle that checks address MEM_SIZE-1
//   ok_o         : no mismatch so far, including this cycle (use with last_o)
//   err_addr_o   : first mismatching address, including this cycle
// -----------------------------------------------------------------------------
module lut_cfg_readback #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2 ** INPUTS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [MEM_SIZE-1:0] frame_i,
    input  logic                lut_rdata_i,
    output logic [INPUTS-1:0]   lut_addr_o,
    output logic                last_o,
    output logic                ok_o,
    output logic [INPUTS-1:0]   err_addr_o
);

    logic              active_q, active_d;
    logic [INPUTS-1:0] addr_q,   addr_d;
    logic              ok_q,     ok_d;
    logic [INPUTS-1:0] err_q,    err_d;

    logic mismatch;
    logic at_end;

    assign mismatch = active_q && (lut_rdata_i != frame_i[addr_q]);
    assign at_end   = active_q && (addr_q == INPUTS'(MEM_SIZE - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        active_d = active_q;
        addr_d   = addr_q;
        ok_d     = ok_q;
        err_d    = err_q;
        if (start_i) begin
            active_d = 1'b1;
            addr_d   = '0;
            ok_d     = 1'b1;
            err_d    = '0;
        end else if (active_q) begin
            // Only the first mismatch is recorded.
            if (mismatch && ok_q) begin
                ok_d  = 1'b0;
                err_d = addr_q;
            end
            if (at_end) begin
                active_d = 1'b0;
                addr_d   = '0;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            ok_q     <= 1'b1;
            err_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            active_q <= active_d;
            addr_q   <= addr_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    assign lut_addr_o = addr_q;
    assign last_o     = at_end;
    // Fold in the current cycle so a mismatch on the final address is not lost.
    assign ok_o       = ok_q & ~mismatch;
    assign err_addr_o = ok_q ? addr_q : err_q;

endmodule

// File: rtl/lut_cfg_loader.sv
// -----------------------------------------------------------------------------
// lut_cfg_loader
// Configuration-side driver for a memory LUT. Assembles CONFIG_WIDTH-bit
// stream words into a MEM_SIZE-bit frame, commits it to the LUT with a
// one-cycle config-enable pulse and optionally reads every LUT bit back.
//   clk, rst   : clock (also the LUT configuration clock), async active-high reset
//   cfg        : slave side of the valid/ready word stream
//   verify_en  : sampled during COMMIT; 1 runs the readback check
//   config_out : last committed frame, to LUT config_in
//   cen_out    : config-enable pulse, to LUT
//   lut_addr   : readback address, to LUT addr (0 outside VERIFY)
//   lut_rdata  : LUT output bit
//   busy       : controller not idle
//   done       : one-cycle pulse at end of a committed frame
//   pass       : valid with done; 1 = readback clean or skipped
//   err_addr   : valid with done when pass=0; first mismatching address
//   frame_err  : one-cycle pulse after a short or long frame
// -----------------------------------------------------------------------------
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2 ** INPUTS,
    parameter int CONFIG_WIDTH = CONFIG_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    lut_cfg_loader_if.slave     cfg,
    input  logic                verify_en,
    output logic [MEM_SIZE-1:0] config_out,
    output logic                cen_out,
    output logic [INPUTS-1:0]   lut_addr,
    input  logic                lut_rdata,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [INPUTS-1:0]   err_addr,
    output logic                frame_err
);

    localparam int WORDS = words_of(MEM_SIZE, CONFIG_WIDTH);
    localparam int CNT_W = cnt_width(WORDS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MEM_SIZE-1:0] shadow_q, shadow_d;
    logic [MEM_SIZE-1:0] config_out_q, config_out_d;
    logic                pass_q, pass_d;
    logic [INPUTS-1:0]   err_addr_q, err_addr_d;
    logic                frame_err_q, frame_err_d;

    logic                xfer;
    logic                last_word;
    logic                frame_end;
    logic                frame_good;
    logic                frame_bad;
    logic [MEM_SIZE-1:0] frame_asm;

    logic                rb_start;
    logic                rb_last;
    logic                rb_ok;
    logic [INPUTS-1:0]   rb_err_addr;

    assign xfer       = cfg.cfg_valid & cfg.cfg_ready;
    assign last_word  = (cnt_q == CNT_W'(WORDS - 1));
    // Any frame-terminating transfer: either the expected last word or a misplaced/missing cfg_last.
    assign frame_end  = xfer & (cfg.cfg_last | last_word);
    assign frame_good = xfer & cfg.cfg_last & last_word;
    assign frame_bad  = xfer & (cfg.cfg_last ^ last_word);

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (frame_good) begin
                    state_d = ST_COMMIT;
                end else if (frame_bad) begin
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    state_d = ST_LOAD;
                end
            end
            ST_COMMIT: state_d = verify_en ? ST_VERIFY : ST_DONE;
            ST_VERIFY: if (rb_last) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        // cfg_ready is forced low while reset is held, not just after it.
        cfg.cfg_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
        cen_out       = (state_q == ST_COMMIT);
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
    end

    // ---------------------------------------------------------------- frame assembly
    always_comb begin
        frame_asm = shadow_q;
        if (xfer) begin
            for (int k = 0; k < WORDS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    frame_asm[k*CONFIG_WIDTH +: CONFIG_WIDTH] = cfg.cfg_data;
                end
            end
        end

        cnt_d    = cnt_q;
        shadow_d = frame_asm;
        if (frame_end) begin
            // Frame finished (committed or discarded): start the next one clean.
            cnt_d    = '0;
            shadow_d = '0;
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
        end

        // The committed register only ever sees a complete frame, merged with its final word.
        config_out_d = frame_good ? frame_asm : config_out_q;
        frame_err_d  = frame_bad;
    end

    // ---------------------------------------------------------------- result capture
    always_comb begin
        pass_d     = pass_q;
        err_addr_d = err_addr_q;
        if ((state_q == ST_COMMIT) && !verify_en) begin
            pass_d     = 1'b1;
            err_addr_d = '0;
        end else if ((state_q == ST_VERIFY) && rb_last) begin
            pass_d     = rb_ok;
            err_addr_d = rb_ok ? '0 : rb_err_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            // NOTE: the shadow frame is a plain register bank, not a RAM, so it can and must be cleared on reset.
            shadow_q     <= '0;
            config_out_q <= '0;
            pass_q       <= 1'b0;
            err_addr_q   <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            config_out_q <= config_out_d;
            pass_q       <= pass_d;
            err_addr_q   <= err_addr_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ---------------------------------------------------------------- readback
    assign rb_start = (state_q == ST_COMMIT) & verify_en;

    lut_cfg_readback #(
        .INPUTS   (INPUTS),
        .MEM_SIZE (MEM_SIZE)
    ) u_readback (
        .clk         (clk),
        .rst         (rst),
        .start_i     (rb_start),
        .frame_i     (config_out_q),
        .lut_rdata_i (lut_rdata),
        .lut_addr_o  (lut_addr),
        .last_o      (rb_last),
        .ok_o        (rb_ok),
        .err_addr_o  (rb_err_addr)
    );

    assign config_out = config_out_q;
    assign pass       = pass_q;
    assign err_addr   = err_addr_q;
    assign frame_err  = frame_err_q;

endmodule
